// File: rtl/pc_stack_pkg.sv
// Shared constants and types for the multi-slot PC stack.
package pc_stack_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [1:0] PC_STACK_NOP  = 2'b00;
  localparam logic [1:0] PC_STACK_PUSH = 2'b01;
  localparam logic [1:0] PC_STACK_POP  = 2'b10;

  localparam logic [1:0] PC_FROM_DATA = 2'b00;
  localparam logic [1:0] PC_FROM_REG  = 2'b01;
  localparam logic [1:0] PC_FROM_INST = 2'b10;

  function automatic nibble_t select_pc_next(input logic [1:0] sel,
                                             input nibble_t    data,
                                             input nibble_t    regval,
                                             input nibble_t    inst_operand);
    nibble_t res;
    case (sel)
      PC_FROM_DATA: res = data;
      PC_FROM_REG:  res = regval;
      PC_FROM_INST: res = inst_operand;
      default:      res = 4'h0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pc_stack_multi_if.sv
// Sequencer-facing signal bundle of the PC stack; master = sequencer, slave = stack.
interface pc_stack_multi_if #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NIBBLES = 3
);
  import pc_stack_pkg::*;

  logic                     halt;
  logic [1:0]               control;
  logic [1:0]               pc_next_sel;
  nibble_t                  regval;
  nibble_t                  data;
  nibble_t                  inst_operand;
  logic [NIBBLES-1:0]       pc_write_enable;
  logic [2:0]               cycle;
  logic                     pc_enable;
  nibble_t                  pc_word;
  logic [$clog2(DEPTH):0]   depth_count;
  logic                     overflow;
  logic                     underflow;

  modport master (
    output halt, control, pc_next_sel, regval, data, inst_operand, pc_write_enable, cycle,
    input  pc_enable, pc_word, depth_count, overflow, underflow
  );

  modport slave (
    input  halt, control, pc_next_sel, regval, data, inst_operand, pc_write_enable, cycle,
    output pc_enable, pc_word, depth_count, overflow, underflow
  );

endinterface

// File: rtl/pc_stack_pointer.sv
// Slot index with push/pop wrap; occupancy count and sticky overflow/underflow
// exist only when PC_STACK_FLAGS_EN is defined.
module pc_stack_pointer
  import pc_stack_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     halt,
  input  logic                     op_en,
  input  logic [1:0]               control,
  output logic [$clog2(DEPTH)-1:0] index,
  output logic [$clog2(DEPTH):0]   depth_count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int unsigned IdxW = $clog2(DEPTH);

  logic            push, pop;
  logic [IdxW-1:0] index_q, index_d;

  assign push = op_en && (control == PC_STACK_PUSH);
  assign pop  = op_en && (control == PC_STACK_POP);

  // Power-of-two depth: natural overflow of the index gives modulo wrap.
  always_comb begin
    index_d = index_q;
    if (push)      index_d = index_q + 1'b1;
    else if (pop)  index_d = index_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset)      index_q <= '0;
    else if (!halt) index_q <= index_d;
  end

  assign index = index_q;

`ifdef PC_STACK_FLAGS_EN
  localparam int unsigned CntW = IdxW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;

  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (push) begin
      if (count_q == Full) overflow_d = 1'b1;
      else                 count_d    = count_q + 1'b1;
    end else if (pop) begin
      if (count_q == '0)   underflow_d = 1'b1;
      else                 count_d     = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (!halt) begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign depth_count = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
`else
  assign depth_count = '0;
  assign overflow    = 1'b0;
  assign underflow   = 1'b0;
`endif

endmodule

// File: rtl/pc_stack_multi.sv
// Multi-slot PC stack: nibble-serial increment, stack index ops and nibble jump writes.
// Optional occupancy/flag logic is enabled with PC_STACK_FLAGS_EN.
module pc_stack_multi
  import pc_stack_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NIBBLES = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  pc_stack_multi_if.slave        bus
);
  localparam int unsigned IdxW  = $clog2(DEPTH);
  localparam logic [2:0]  CycOp = 3'(NIBBLES);

  nibble_t         slot_q [DEPTH][NIBBLES];
  nibble_t         slot_d [DEPTH][NIBBLES];
  logic            carry_q, carry_d;
  logic [IdxW-1:0] index;
  nibble_t         pc_next;
  logic [4:0]      sum;
  logic            wr_done;

  pc_stack_pointer #(
    .DEPTH(DEPTH)
  ) u_pointer (
    .clock       (clock),
    .reset       (reset),
    .halt        (bus.halt),
    .op_en       (bus.cycle == CycOp),
    .control     (bus.control),
    .index       (index),
    .depth_count (bus.depth_count),
    .overflow    (bus.overflow),
    .underflow   (bus.underflow)
  );

  assign pc_next = select_pc_next(bus.pc_next_sel, bus.data, bus.regval, bus.inst_operand);

  always_comb begin
    slot_d  = slot_q;
    carry_d = carry_q;
    sum     = '0;
    wr_done = 1'b0;
    // Ripple increment: nibble 0 always adds one, higher nibbles add the saved carry.
    for (int k = 0; k < NIBBLES; k++) begin
      if (bus.cycle == 3'(k)) begin
        sum = {1'b0, slot_q[index][k]} + ((k == 0) ? 5'd1 : {4'd0, carry_q});
        slot_d[index][k] = sum[3:0];
        carry_d          = sum[4];
      end
    end
    // Jump writes: only the lowest requested nibble is taken.
    if (bus.cycle > CycOp) begin
      for (int k = 0; k < NIBBLES; k++) begin
        if (bus.pc_write_enable[k] && !wr_done) begin
          slot_d[index][k] = pc_next;
          wr_done          = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int d = 0; d < DEPTH; d++) begin
        for (int k = 0; k < NIBBLES; k++) begin
          slot_q[d][k] <= '0;
        end
      end
      carry_q <= 1'b0;
    end else if (!bus.halt) begin
      slot_q  <= slot_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    bus.pc_word   = '0;
    bus.pc_enable = (bus.cycle <= CycOp);
    for (int k = 0; k < NIBBLES; k++) begin
      if (bus.cycle == 3'(k)) bus.pc_word = slot_q[index][k];
    end
  end

endmodule

// File: doc/pc_stack_multi.md
# pc_stack_multi

Parametrised program-counter stack for the nibble-serial CPU core: `DEPTH` PC slots, each `4*NIBBLES` bits wide. Each instruction it does three things:
- streams the active PC out one nibble per cycle while incrementing it with a ripple carry;
- applies a push/pop to the slot index;
- accepts nibble-granular jump writes from data, register or instruction operand.

It sits between the sequencer (which supplies `cycle`, `control`, write enables) and the bus mux. It adds arbitrary depth, wider PCs, occupancy tracking and overflow/underflow detection.

## Interface
Parameters:
- `DEPTH`, 4, number of PC slots; power of two, 2..16.
- `NIBBLES`, 3, nibbles per PC; 2..6 (PC width `4*NIBBLES`).

Ports:
- `clock` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `halt` in 1: freezes all state while high.
- `control` in 2: stack op.
- `pc_next_sel` in 2: write source select.
- `regval`, `data`, `inst_operand` in 4 each: write sources.
- `pc_write_enable` in `NIBBLES`: per-nibble write request.
- `cycle` in 3: instruction sub-cycle from sequencer.
- `pc_enable` out 1: PC drives bus this cycle.
- `pc_word` out 4: PC nibble.
- `depth_count` out `$clog2(DEPTH)+1`: occupied slots above base.
- `overflow` out 1: sticky.
- `underflow` out 1: sticky.

## Operation
- State:
  - slot array;
  - `index` (`$clog2(DEPTH)` bits);
  - `carry`;
  - `count` (0..DEPTH);
  - sticky `overflow` and `underflow`.
- Active slot is always `slot[index]`.
- Cycle `k`, for `k < NIBBLES`: nibble `k` of the active slot gets `nibble + (k==0 ? 1 : carry)`; `carry` takes the carry-out.
  - Carry out of the top nibble is discarded, so all-ones wraps to 0.
- Cycle `NIBBLES` applies `control`:
  - `NOP` (00): no change.
  - `PUSH` (01): `index+1` modulo `DEPTH`. The new slot keeps its stale contents; the sequencer writes the target afterwards.
    - If `count == DEPTH`: `overflow` is set, `count` holds, index still wraps (oldest entry is overwritten).
    - Otherwise `count+1`.
  - `POP` (10): `index-1` modulo `DEPTH`.
    - If `count == 0`: `underflow` is set, count holds at 0, index still wraps.
    - Otherwise `count-1`.
  - `11`: reserved, treated as NOP.
- Cycles greater than `NIBBLES` with any `pc_write_enable` bit set:
  - only the lowest set bit `j` takes effect;
  - nibble `j` of the active slot gets `pc_next`.
- `pc_next` by `pc_next_sel`:
  - `PC_FROM_DATA` (00): `data`.
  - `PC_FROM_REG` (01): `regval`.
  - `PC_FROM_INST` (10): `inst_operand`.
  - `11`: `4'h0`.
- `pc_write_enable` is ignored in cycles 0..`NIBBLES`.
- `halt` high: no state changes (slots, index, carry, count, flags). Outputs still follow `cycle`.
- Flags are cleared only by reset.

## Timing
- Reset (synchronous, dominates `halt`): all slots, `index`, `carry`, `count`, `overflow`, `underflow` go to 0.
  - Reset mid-instruction discards any partial increment.
- Outputs are combinational from `cycle` and the current state:
  - `cycle < NIBBLES`: `pc_word` = nibble `cycle` of the active slot, `pc_enable` = 1.
  - `cycle == NIBBLES`: `pc_word` = 0, `pc_enable` = 1.
  - Otherwise: `pc_word` = 0, `pc_enable` = 0.
- The displayed nibble is the pre-increment value. The incremented value is visible from the next instruction.
- The new `index` takes effect in cycle `NIBBLES+1`; writes in that instruction go to the new slot.
- Flags and `depth_count` are registered and update at the end of cycle `NIBBLES`.

## Configuration
- `PC_STACK_FLAGS_EN` defined: `count`, `overflow` and `underflow` logic is present as described.
- Not defined: no count or flag registers; `depth_count`, `overflow` and `underflow` are tied to 0; index wraps silently. Ports remain, so integration is unchanged.

## Structure
- Shared package / include `pc_stack_pkg`:
  - `PC_STACK_NOP`, `PC_STACK_PUSH`, `PC_STACK_POP`;
  - `PC_FROM_DATA`, `PC_FROM_REG`, `PC_FROM_INST`;
  - a typedef for the 4-bit nibble.
- Sub-module `pc_stack_pointer` holds `index`, `count`, the overflow/underflow logic and the `PC_STACK_FLAGS_EN` guard.
- The top level holds the slot array, incrementer, write mux and output mux.

## Test plan
Run at `DEPTH=4, NIBBLES=3` unless noted.
1. Reset, run 3 NOP instructions: `pc_word` sequence per instruction is 0,0,0 / 1,0,0 / 2,0,0; `pc_enable` is high in cycles 0..3 only.
2. Preload slot 0 with `0x0FF` via writes (data=F to nibbles 0,1), then NOP: emitted nibbles F,F,0; next instruction emits 0,0,1 (carry ripple into nibble 2).
3. Preload `0xFFF`, NOP: next instruction emits 0,0,0 (top carry discarded).
4. PUSH, then in cycle 4 write nibble 0 from `inst_operand=5` with `pc_write_enable=3'b011`: only nibble 0 is written; next instruction emits 5 from slot 1; `depth_count`=1. POP: slot 0 resumes at its saved PC.
5. With `PC_STACK_FLAGS_EN` defined: 5 PUSHes give `overflow=1`, `depth_count=4`, index 1; POP from reset gives `underflow=1`, `depth_count=0`, index 3; both stay set until reset.
6. `halt` high across a full instruction: no change in the next instruction's nibbles, index or count. Reset asserted at cycle 1: all outputs/state are 0 the following cycle.
